// File: rtl/trans_pkg.sv
// Shared widths, the transaction struct, and a saturating-increment helper for trans_drive_mon.
package trans_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 32;
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              write;
    logic [ID_W-1:0]   id;
  } trans_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/trans_drive_mon_if.sv
// Driver/bus/monitor signal bundle; slave side is the trans_drive_mon block.
interface trans_drive_mon_if;
  import trans_pkg::*;

  logic              drv_valid;
  logic [ADDR_W-1:0] drv_addr;
  logic [DATA_W-1:0] drv_data;
  logic              drv_write;
  logic [ID_W-1:0]   drv_id;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data;
  logic              bus_write;
  logic [ID_W-1:0]   bus_id;
  logic              mon_req;
  logic              mon_valid;
  logic [ADDR_W-1:0] mon_addr;
  logic [DATA_W-1:0] mon_data;
  logic              mon_write;
  logic [ID_W-1:0]   mon_id;
  logic [CNT_W-1:0]  drv_count;
  logic              cmp_mismatch;
  logic [CNT_W-1:0]  cmp_match_cnt;
  logic [CNT_W-1:0]  cmp_miss_cnt;

  modport master (
    output drv_valid, drv_addr, drv_data, drv_write, drv_id, mon_req,
    input  bus_addr, bus_data, bus_write, bus_id,
    input  mon_valid, mon_addr, mon_data, mon_write, mon_id,
    input  drv_count, cmp_mismatch, cmp_match_cnt, cmp_miss_cnt
  );

  modport slave (
    input  drv_valid, drv_addr, drv_data, drv_write, drv_id, mon_req,
    output bus_addr, bus_data, bus_write, bus_id,
    output mon_valid, mon_addr, mon_data, mon_write, mon_id,
    output drv_count, cmp_mismatch, cmp_match_cnt, cmp_miss_cnt
  );

endinterface

// File: rtl/trans_cmp.sv
// Expected-transaction register, field compare and saturating match/miss counters.
module trans_cmp
  import trans_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_drv_valid,
  input  trans_t           i_drv,
  input  logic             i_mon_valid,
  input  trans_t           i_mon,
  output logic             o_mismatch,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic [CNT_W-1:0] o_miss_cnt
);

  trans_t           r_exp;
  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] r_miss_cnt;
  logic             w_diff;

  assign w_diff = (i_mon.addr  != r_exp.addr)  ||
                  (i_mon.data  != r_exp.data)  ||
                  (i_mon.write != r_exp.write) ||
                  (i_mon.id    != r_exp.id);

  // Pulse lives in the mon_valid cycle itself; counters reflect it from the next cycle.
  assign o_mismatch  = i_mon_valid && w_diff;
  assign o_match_cnt = r_match_cnt;
  assign o_miss_cnt  = r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp       <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
    end else begin
      if (i_drv_valid) r_exp <= i_drv;
      if (i_mon_valid) begin
        if (w_diff) r_miss_cnt  <= sat_inc(r_miss_cnt);
        else        r_match_cnt <= sat_inc(r_match_cnt);
      end
    end
  end

endmodule

// File: rtl/trans_drive_mon.sv
// Registered driver->bus->monitor transaction stage. Define TRANS_CMP_EN to add the
// expected-vs-monitored comparator (trans_cmp); otherwise cmp_* outputs are tied to 0.
module trans_drive_mon #(
  parameter int unsigned ADDR_W = trans_pkg::ADDR_W,
  parameter int unsigned DATA_W = trans_pkg::DATA_W,
  parameter int unsigned ID_W   = trans_pkg::ID_W,
  parameter int unsigned CNT_W  = trans_pkg::CNT_W
) (
  input logic              clk,
  input logic              rst,
  trans_drive_mon_if.slave tif
);
  import trans_pkg::trans_t;

  logic [ADDR_W-1:0] w_drv_addr;
  logic [DATA_W-1:0] w_drv_data;
  logic [ID_W-1:0]   w_drv_id;
  trans_t            w_drv;
  trans_t            r_bus;
  trans_t            r_mon;
  logic              r_mon_valid;
  logic [CNT_W-1:0]  r_drv_count;

  assign w_drv_addr = tif.drv_addr;
  assign w_drv_data = tif.drv_data;
  assign w_drv_id   = tif.drv_id;
  assign w_drv      = '{addr: w_drv_addr, data: w_drv_data, write: tif.drv_write, id: w_drv_id};

  // Monitor samples r_bus before this edge's drive lands, so same-edge capture sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus       <= '0;
      r_mon       <= '0;
      r_mon_valid <= 1'b0;
      r_drv_count <= '0;
    end else begin
      r_mon_valid <= tif.mon_req;
      if (tif.mon_req) r_mon <= r_bus;
      if (tif.drv_valid) begin
        r_bus       <= w_drv;
        r_drv_count <= r_drv_count + CNT_W'(1);
      end
    end
  end

  assign tif.bus_addr  = r_bus.addr;
  assign tif.bus_data  = r_bus.data;
  assign tif.bus_write = r_bus.write;
  assign tif.bus_id    = r_bus.id;
  assign tif.mon_valid = r_mon_valid;
  assign tif.mon_addr  = r_mon.addr;
  assign tif.mon_data  = r_mon.data;
  assign tif.mon_write = r_mon.write;
  assign tif.mon_id    = r_mon.id;
  assign tif.drv_count = r_drv_count;

`ifdef TRANS_CMP_EN
  trans_cmp u_cmp (
    .clk         (clk),
    .rst         (rst),
    .i_drv_valid (tif.drv_valid),
    .i_drv       (w_drv),
    .i_mon_valid (r_mon_valid),
    .i_mon       (r_mon),
    .o_mismatch  (tif.cmp_mismatch),
    .o_match_cnt (tif.cmp_match_cnt),
    .o_miss_cnt  (tif.cmp_miss_cnt)
  );
`else
  assign tif.cmp_mismatch  = 1'b0;
  assign tif.cmp_match_cnt = '0;
  assign tif.cmp_miss_cnt  = '0;
`endif

endmodule

// File: tb/tb_trans_drive_mon.sv
// Directed + randomized bench for trans_drive_mon against a transaction-level reference model.
module tb_trans_drive_mon;
  import trans_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  trans_drive_mon_if tif();

  trans_drive_mon #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tif (tif)
  );

  always #5 clk = ~clk;

  // Reference model: what the bus holds, what the monitor last saw, and the tallies.
  trans_t m_bus, m_mon;
  bit     m_mv, m_mism;
  int     m_cnt, m_match, m_miss;

  function automatic void model_reset();
    m_bus = '0; m_mon = '0; m_mv = 0; m_mism = 0;
    m_cnt = 0; m_match = 0; m_miss = 0;
  endfunction

  // The expected register always mirrors the last accepted drive, i.e. the current bus value.
  function automatic void model_edge(input bit dv, input trans_t d, input bit rq);
    if (m_mv) begin
      if (m_mon != m_bus) m_miss  = (m_miss  < 65535) ? m_miss  + 1 : 65535;
      else                m_match = (m_match < 65535) ? m_match + 1 : 65535;
    end
    m_mv = rq;
    if (rq) m_mon = m_bus;
    if (dv) begin
      m_bus = d;
      m_cnt = (m_cnt + 1) % 65536;
    end
    m_mism = m_mv && (m_mon != m_bus);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit e_mm;
    int e_match, e_miss;
`ifdef TRANS_CMP_EN
    e_mm = m_mism; e_match = m_match; e_miss = m_miss;
`else
    e_mm = 0; e_match = 0; e_miss = 0;
`endif
    chk({tag, ".bus_addr"},  64'(tif.bus_addr),  64'(m_bus.addr));
    chk({tag, ".bus_data"},  64'(tif.bus_data),  64'(m_bus.data));
    chk({tag, ".bus_write"}, 64'(tif.bus_write), 64'(m_bus.write));
    chk({tag, ".bus_id"},    64'(tif.bus_id),    64'(m_bus.id));
    chk({tag, ".mon_valid"}, 64'(tif.mon_valid), 64'(m_mv));
    chk({tag, ".mon_addr"},  64'(tif.mon_addr),  64'(m_mon.addr));
    chk({tag, ".mon_data"},  64'(tif.mon_data),  64'(m_mon.data));
    chk({tag, ".mon_write"}, 64'(tif.mon_write), 64'(m_mon.write));
    chk({tag, ".mon_id"},    64'(tif.mon_id),    64'(m_mon.id));
    chk({tag, ".drv_count"}, 64'(tif.drv_count), 64'(m_cnt));
    chk({tag, ".cmp_mismatch"},  64'(tif.cmp_mismatch),  64'(e_mm));
    chk({tag, ".cmp_match_cnt"}, 64'(tif.cmp_match_cnt), 64'(e_match));
    chk({tag, ".cmp_miss_cnt"},  64'(tif.cmp_miss_cnt),  64'(e_miss));
  endtask

  function automatic trans_t rnd_trans();
    trans_t t;
    t.addr  = 8'($urandom);
    t.data  = $urandom;
    t.write = 1'($urandom);
    t.id    = $urandom;
    return t;
  endfunction

  // Drives inputs away from the edge, advances one clock, updates the model, samples 1 unit later.
  task automatic step(input bit dv, input trans_t d, input bit rq, input bit do_chk, input string tag);
    tif.drv_valid = dv;
    tif.drv_addr  = d.addr;
    tif.drv_data  = d.data;
    tif.drv_write = d.write;
    tif.drv_id    = d.id;
    tif.mon_req   = rq;
    @(posedge clk);
    model_edge(dv, d, rq);
    #1;
    if (do_chk) check_all(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    trans_t t10, t14, t18, tw;
    t10 = '{addr: 8'h10, data: 32'h11223344, write: 1'b1, id: 32'h1000};
    t14 = '{addr: 8'h14, data: 32'h55667788, write: 1'b0, id: 32'h1001};
    t18 = '{addr: 8'h18, data: 32'h99AABBCC, write: 1'b1, id: 32'h1002};

    tif.drv_valid = 0; tif.drv_addr = '0; tif.drv_data = '0;
    tif.drv_write = 0; tif.drv_id = '0; tif.mon_req = 0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    check_all("release");

    // Single drive, sampled 10 cycles later
    step(1, t10, 0, 1, "drive1");
    for (int i = 0; i < 10; i++) step(0, rnd_trans(), 0, 1, "hold");
    step(0, rnd_trans(), 1, 1, "sample1");
    chk("sample1.mon_addr_const", 64'(tif.mon_addr), 64'h10);
    chk("sample1.mon_id_const", 64'(tif.mon_id), 64'h1000);
    chk("sample1.mon_valid_const", 64'(tif.mon_valid), 64'h1);
    step(0, rnd_trans(), 0, 1, "after1");
    chk("after1.mon_valid_pulse", 64'(tif.mon_valid), 64'h0);
    chk("after1.drv_count_const", 64'(tif.drv_count), 64'h1);
`ifdef TRANS_CMP_EN
    chk("after1.match_const", 64'(tif.cmp_match_cnt), 64'h1);
`endif

    // Two more drive/sample pairs
    step(1, t14, 0, 1, "drive2");
    step(0, rnd_trans(), 1, 1, "sample2");
    chk("sample2.mon_data_const", 64'(tif.mon_data), 64'h55667788);
    step(0, rnd_trans(), 0, 1, "after2");
    step(1, t18, 0, 1, "drive3");
    step(0, rnd_trans(), 1, 1, "sample3");
    chk("sample3.mon_data_const", 64'(tif.mon_data), 64'h99AABBCC);
    step(0, rnd_trans(), 0, 1, "after3");
    chk("after3.drv_count_const", 64'(tif.drv_count), 64'h3);
    chk("after3.miss_const", 64'(tif.cmp_miss_cnt), 64'h0);

    // Same-edge drive and sample: monitor sees the old bus value
    step(1, t10, 0, 1, "redrive10");
    step(1, t14, 1, 1, "same_edge");
    chk("same_edge.mon_addr_const", 64'(tif.mon_addr), 64'h10);
    chk("same_edge.bus_addr_const", 64'(tif.bus_addr), 64'h14);
`ifdef TRANS_CMP_EN
    chk("same_edge.mismatch_const", 64'(tif.cmp_mismatch), 64'h1);
`endif
    step(0, rnd_trans(), 0, 1, "same_edge_after");
`ifdef TRANS_CMP_EN
    chk("same_edge.miss_const", 64'(tif.cmp_miss_cnt), 64'h1);
`endif

    // Randomized traffic, including held mon_req bursts
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), rnd_trans(), 1'($urandom_range(0, 1)), 1, "random");

    // Asynchronous reset between edges while a sample is pending
    tif.mon_req = 1'b1;
    tif.drv_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("rst_held");
    rst = 1'b0;
    step(0, rnd_trans(), 0, 1, "rst_release");
    chk("rst_release.mon_valid_const", 64'(tif.mon_valid), 64'h0);

    // 2^16 back-to-back drives with continuous sampling: count wraps, miss counter saturates
    for (int i = 0; i < 65535; i++) begin
      tw = '{addr: 8'(i), data: 32'(i), write: 1'(i), id: ~32'(i)};
      step(1, tw, 1, 0, "wrap");
    end
    check_all("wrap_ffff");
    chk("wrap.count_ffff_const", 64'(tif.drv_count), 64'hFFFF);
    tw = '{addr: 8'hA5, data: 32'hDEADBEEF, write: 1'b0, id: 32'h5A5A};
    step(1, tw, 1, 1, "wrap_zero");
    chk("wrap.count_zero_const", 64'(tif.drv_count), 64'h0);
    for (int i = 0; i < 4; i++) step(1, rnd_trans(), 1, 1, "sat");
    step(0, rnd_trans(), 0, 1, "sat_end");
`ifdef TRANS_CMP_EN
    chk("sat.miss_ffff_const", 64'(tif.cmp_miss_cnt), 64'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
